qei_multimode: RTL and testbench

- Parametrised quadrature encoder interface core; next generation of the single-mode x4 pin-level decoder.
- Adds configurable counter width, per-input glitch filtering, x1/x2/x4 decode modes, direction inversion, index (Z) latch/clear, and illegal-transition error detection.
- Instantiated per encoder channel behind the top-level pin wrapper.

---
 rtl/qei_pkg.sv | 67 ++++++
 rtl/qei_filter.sv | 56 +++++
 rtl/qei_multimode.sv | 146 ++++++++++++++
 tb/tb_qei_multimode.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qei_pkg.sv
// rtl/qei_pkg.sv - shared constants, step type and decode helpers for qei_multimode
// Contents:
//   QEI_MODE_X4/X2/X1  decode mode selects (2'b11 behaves as x4)
//   QEI_ST_*           quadrature state encodings {A,B}
//   step_e             per-cycle decode result
//   qei_decode()       classifies a {A,B} transition for a given mode
package qei_pkg;

  localparam logic [1:0] QEI_MODE_X4 = 2'b00;
  localparam logic [1:0] QEI_MODE_X2 = 2'b01;
  localparam logic [1:0] QEI_MODE_X1 = 2'b10;

  localparam logic [1:0] QEI_ST_00 = 2'b00;
  localparam logic [1:0] QEI_ST_01 = 2'b01;
  localparam logic [1:0] QEI_ST_11 = 2'b11;
  localparam logic [1:0] QEI_ST_10 = 2'b10;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    FWD     = 2'd1,
    BWD     = 2'd2,
    ILLEGAL = 2'd3
  } step_e;

  // Forward cycle is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] qei_next_fwd(input logic [1:0] s);
    case (s)
      QEI_ST_00: return QEI_ST_01;
      QEI_ST_01: return QEI_ST_11;
      QEI_ST_11: return QEI_ST_10;
      default:   return QEI_ST_00;
    endcase
  endfunction

  function automatic logic [1:0] qei_next_bwd(input logic [1:0] s);
    case (s)
      QEI_ST_00: return QEI_ST_10;
      QEI_ST_10: return QEI_ST_11;
      QEI_ST_11: return QEI_ST_01;
      default:   return QEI_ST_00;
    endcase
  endfunction

  // prev/cur are {A,B}. A simultaneous A and B change is illegal in every mode.
  function automatic step_e qei_decode(input logic [1:0] mode,
                                       input logic [1:0] prev,
                                       input logic [1:0] cur);
    step_e r;
    logic  a_chg;
    logic  b_chg;
    a_chg = prev[1] ^ cur[1];
    b_chg = prev[0] ^ cur[0];
    r = NONE;
    if (a_chg && b_chg) begin
      r = ILLEGAL;
    end else if (mode == QEI_MODE_X2) begin
      if (a_chg) r = (cur[1] == cur[0]) ? FWD : BWD;
    end else if (mode == QEI_MODE_X1) begin
      if (a_chg && cur[1]) r = cur[0] ? FWD : BWD;
    end else begin
      if (cur == qei_next_fwd(prev))      r = FWD;
      else if (cur == qei_next_bwd(prev)) r = BWD;
    end
    return r;
  endfunction

endpackage

// File: rtl/qei_filter.sv
// rtl/qei_filter.sv - two-flop synchroniser plus stable-count glitch filter for one encoder pin
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   raw         asynchronous pin input
//   filt        filtered, synchronised level
module qei_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign filt = sync2;
    end else begin : g_filter
      localparam int CW = $clog2(FILT_LEN + 1);
      logic [CW-1:0] cnt;
      logic          level;

      // cnt counts consecutive cycles the synchronised value has disagreed
      // with the held level; agreement (a bounce back) restarts it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (sync2 == level) begin
          cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign filt = level;
    end
  endgenerate

endmodule

// File: rtl/qei_multimode.sv
// rtl/qei_multimode.sv - multimode (x1/x2/x4) quadrature encoder interface with index and error detection
// Optional feature macro: QEI_VELOCITY_EN (windowed signed velocity measurement)
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   a_in, b_in, z_in         asynchronous encoder pins
//   mode                     00=x4, 01=x2, 10=x1, 11=x4
//   invert_dir               swap forward/backward
//   idx_clr_en               index rising edge clears count
//   clr_count, clr_err       synchronous clears
//   count, dir, step         position, last direction, step pulse
//   index_pos, index_seen    count captured at index edge, sticky index flag
//   err                      sticky illegal-transition flag
//   vel, vel_valid           velocity per window and update pulse (0 without feature)
module qei_multimode
  import qei_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int FILT_LEN   = 3,
  parameter int VEL_PERIOD = 1000,
  parameter int VEL_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_in,
  input  logic                    b_in,
  input  logic                    z_in,
  input  logic [1:0]              mode,
  input  logic                    invert_dir,
  input  logic                    idx_clr_en,
  input  logic                    clr_count,
  input  logic                    clr_err,
  output logic [CNT_W-1:0]        count,
  output logic                    dir,
  output logic                    step,
  output logic [CNT_W-1:0]        index_pos,
  output logic                    index_seen,
  output logic                    err,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid
);

  logic       a_f;
  logic       b_f;
  logic       z_f;
  logic [1:0] prev_ab;
  logic       prev_z;
  step_e      raw_step;
  step_e      dstep;
  logic       counted;
  logic       z_rise;

  qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk(clk), .rst_n(rst_n), .raw(a_in), .filt(a_f));
  qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk(clk), .rst_n(rst_n), .raw(b_in), .filt(b_f));
  qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (.clk(clk), .rst_n(rst_n), .raw(z_in), .filt(z_f));

  // Inversion is applied to the decoded step so it affects count, dir and
  // velocity consistently.
  always_comb begin
    raw_step = qei_decode(mode, prev_ab, {a_f, b_f});
    dstep    = raw_step;
    if (invert_dir) begin
      if (raw_step == FWD)      dstep = BWD;
      else if (raw_step == BWD) dstep = FWD;
    end
  end

  assign counted = (dstep == FWD) || (dstep == BWD);
  assign z_rise  = z_f & ~prev_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab    <= 2'b00;
      prev_z     <= 1'b0;
      count      <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
      index_pos  <= '0;
      index_seen <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_ab <= {a_f, b_f};
      prev_z  <= z_f;
      step    <= counted;

      if (counted) dir <= (dstep == FWD);

      if (dstep == ILLEGAL) err <= 1'b1;
      else if (clr_err)     err <= 1'b0;

      // index_pos takes the value before any update this cycle.
      if (z_rise) begin
        index_pos  <= count;
        index_seen <= 1'b1;
      end

      if (clr_count)                count <= '0;
      else if (z_rise && idx_clr_en) count <= '0;
      else if (dstep == FWD)         count <= count + CNT_W'(1);
      else if (dstep == BWD)         count <= count - CNT_W'(1);
    end
  end

`ifdef QEI_VELOCITY_EN
  localparam int                 WIN_W   = $clog2(VEL_PERIOD);
  localparam logic signed [31:0] VEL_MAX = (32'sd1 <<< (VEL_W - 1)) - 32'sd1;

  logic [WIN_W-1:0]        win;
  logic signed [31:0]      acc;
  logic signed [31:0]      acc_next;
  logic signed [VEL_W-1:0] vel_sat;

  always_comb begin
    acc_next = acc;
    if (dstep == FWD)      acc_next = acc + 32'sd1;
    else if (dstep == BWD) acc_next = acc - 32'sd1;

    if (acc_next > VEL_MAX)       vel_sat = VEL_W'(VEL_MAX);
    else if (acc_next < -VEL_MAX) vel_sat = VEL_W'(-VEL_MAX);
    else                          vel_sat = VEL_W'(acc_next);
  end

  // The window free-runs from reset; clr_count deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= '0;
      acc       <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
    end else if (win == WIN_W'(VEL_PERIOD - 1)) begin
      win       <= '0;
      acc       <= '0;
      vel       <= vel_sat;
      vel_valid <= 1'b1;
    end else begin
      win       <= win + WIN_W'(1);
      acc       <= acc_next;
      vel_valid <= 1'b0;
    end
  end
`else
  localparam int unused_vel_period = VEL_PERIOD;
  assign vel       = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qei_multimode.sv
// tb/tb_qei_multimode.sv - directed self-checking bench for qei_multimode
module tb_qei_multimode;

  localparam int CNT_W      = 16;
  localparam int FILT_LEN   = 3;
  localparam int VEL_PERIOD = 100;
  localparam int VEL_W      = 12;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    a_in = 1'b0;
  logic                    b_in = 1'b0;
  logic                    z_in = 1'b0;
  logic [1:0]              mode = 2'b00;
  logic                    invert_dir = 1'b0;
  logic                    idx_clr_en = 1'b0;
  logic                    clr_count = 1'b0;
  logic                    clr_err = 1'b0;
  logic [CNT_W-1:0]        count;
  logic                    dir;
  logic                    step;
  logic [CNT_W-1:0]        index_pos;
  logic                    index_seen;
  logic                    err;
  logic signed [VEL_W-1:0] vel;
  logic                    vel_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int step_cnt = 0;
  int vv_cnt = 0;

  qei_multimode #(
    .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_PERIOD(VEL_PERIOD), .VEL_W(VEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .z_in(z_in),
    .mode(mode), .invert_dir(invert_dir), .idx_clr_en(idx_clr_en),
    .clr_count(clr_count), .clr_err(clr_err), .count(count), .dir(dir),
    .step(step), .index_pos(index_pos), .index_seen(index_seen), .err(err),
    .vel(vel), .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (step) step_cnt++;
    if (vel_valid) vv_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] s, input bit fwd);
    case (s)
      2'b00:   nxt = fwd ? 2'b01 : 2'b10;
      2'b01:   nxt = fwd ? 2'b11 : 2'b00;
      2'b11:   nxt = fwd ? 2'b10 : 2'b01;
      default: nxt = fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic drive(input logic [1:0] ab, input int hold);
    {a_in, b_in} = ab;
    tick(hold);
  endtask

  // One 10-cycle step: no pulse 5 edges after the pin change, pulse on the 6th.
  task automatic step_chk(input string tag, input logic [1:0] ab,
                          input logic [CNT_W-1:0] exp_cnt, input logic exp_dir);
    {a_in, b_in} = ab;
    tick(5);
    chk({tag, "_early"}, step, 0);
    tick(1);
    chk({tag, "_step"}, step, 1);
    chk({tag, "_count"}, count, exp_cnt);
    chk({tag, "_dir"}, dir, exp_dir);
    tick(4);
  endtask

  task automatic pulse_clr_count();
    clr_count = 1'b1;
    tick(1);
    clr_count = 1'b0;
  endtask

  logic [1:0]       st;
  logic [CNT_W-1:0] exp_c;
  int               sc0;
  int               vv0;

  initial begin
    tick(3);
    chk("rst_count", count, 0);
    chk("rst_dir", dir, 0);
    chk("rst_step", step, 0);
    chk("rst_index_pos", index_pos, 0);
    chk("rst_index_seen", index_seen, 0);
    chk("rst_err", err, 0);
    chk("rst_vel", vel, 0);
    chk("rst_vel_valid", vel_valid, 0);
    rst_n = 1'b1;
    tick(2);

    // x4 forward, 8 steps
    st = 2'b00;
    exp_c = '0;
    sc0 = step_cnt;
    for (int i = 0; i < 8; i++) begin
      st = nxt(st, 1'b1);
      exp_c = exp_c + 1'b1;
      step_chk("x4_fwd", st, exp_c, 1'b1);
    end
    chk("x4_fwd_pulses", step_cnt - sc0, 8);

    pulse_clr_count();
    chk("clr_count", count, 0);
    chk("clr_keeps_dir", dir, 1);

    // x4 backward through zero, then forward back
    for (int i = 0; i < 3; i++) begin
      st = nxt(st, 1'b0);
      exp_c = exp_c - 1'b1;
      if (i == 0) exp_c = 16'hFFFF;
      step_chk("x4_bwd", st, exp_c, 1'b0);
    end
    chk("x4_bwd_wrap", count, 16'hFFFD);
    for (int i = 0; i < 3; i++) begin
      st = nxt(st, 1'b1);
      exp_c = exp_c + 1'b1;
      step_chk("x4_fwd_wrap", st, exp_c, 1'b1);
    end
    chk("x4_back_to_zero", count, 0);

    // 2-cycle A glitch must be rejected
    sc0 = step_cnt;
    a_in = 1'b1;
    tick(2);
    a_in = 1'b0;
    tick(10);
    chk("glitch_count", count, 0);
    chk("glitch_steps", step_cnt - sc0, 0);
    chk("glitch_err", err, 0);

    // x1: 4 full forward cycles
    mode = 2'b10;
    for (int i = 0; i < 16; i++) begin
      st = nxt(st, 1'b1);
      drive(st, 6);
    end
    tick(6);
    chk("x1_count", count, 4);
    chk("x1_dir", dir, 1);

    // x2: 4 full forward cycles
    mode = 2'b01;
    pulse_clr_count();
    for (int i = 0; i < 16; i++) begin
      st = nxt(st, 1'b1);
      drive(st, 6);
    end
    tick(6);
    chk("x2_count", count, 8);

    // x2: one backward cycle
    for (int i = 0; i < 4; i++) begin
      st = nxt(st, 1'b0);
      drive(st, 6);
    end
    tick(6);
    chk("x2_bwd_count", count, 6);
    chk("x2_bwd_dir", dir, 0);

    // illegal transitions
    mode = 2'b00;
    sc0 = step_cnt;
    {a_in, b_in} = 2'b11;
    tick(8);
    chk("illegal_err", err, 1);
    chk("illegal_count", count, 6);
    chk("illegal_steps", step_cnt - sc0, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err", err, 0);
    {a_in, b_in} = 2'b00;
    tick(5);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("illegal_beats_clr_err", err, 1);
    tick(4);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err_again", err, 0);
    st = 2'b00;

    // index clear at count 37
    pulse_clr_count();
    for (int i = 0; i < 37; i++) begin
      st = nxt(st, 1'b1);
      drive(st, 5);
    end
    tick(6);
    chk("pre_index_count", count, 37);
    idx_clr_en = 1'b1;
    z_in = 1'b1;
    tick(5);
    chk("index_not_yet", index_seen, 0);
    tick(1);
    chk("index_pos", index_pos, 37);
    chk("index_seen", index_seen, 1);
    chk("index_clear", count, 0);
    z_in = 1'b0;
    idx_clr_en = 1'b0;
    tick(8);

    // index capture without clear
    for (int i = 0; i < 2; i++) begin
      st = nxt(st, 1'b1);
      drive(st, 6);
    end
    tick(6);
    z_in = 1'b1;
    tick(8);
    chk("index_pos_noclr", index_pos, 2);
    chk("count_noclr", count, 2);
    z_in = 1'b0;
    tick(8);

    // clr_count coincident with a forward step
    st = nxt(st, 1'b1);
    {a_in, b_in} = st;
    tick(5);
    clr_count = 1'b1;
    tick(1);
    clr_count = 1'b0;
    chk("clr_vs_step_count", count, 0);
    chk("clr_vs_step_pulse", step, 1);
    tick(4);

    // invert_dir turns a forward pin step into a decrement
    invert_dir = 1'b1;
    st = nxt(st, 1'b1);
    step_chk("invert", st, 16'hFFFF, 1'b0);
    invert_dir = 1'b0;

`ifdef QEI_VELOCITY_EN
    // 25 forward steps inside the first window after reset
    {a_in, b_in} = 2'b00;
    z_in = 1'b0;
    rst_n = 1'b0;
    tick(2);
    chk("vel_after_rst", vel, 0);
    rst_n = 1'b1;
    st = 2'b00;
    vv0 = vv_cnt;
    for (int i = 0; i < 25; i++) begin
      st = nxt(st, 1'b1);
      drive(st, 3);
    end
    tick(24);
    chk("vel_valid_before_end", vel_valid, 0);
    tick(1);
    chk("vel_valid_pulse", vel_valid, 1);
    chk("vel_25", vel, 25);
    tick(2);
    chk("vel_single_pulse", vv_cnt - vv0, 1);

    // reset mid-window, then window restarts from release
    for (int i = 0; i < 10; i++) begin
      st = nxt(st, 1'b1);
      drive(st, 3);
    end
    {a_in, b_in} = 2'b00;
    rst_n = 1'b0;
    tick(1);
    chk("vel_midrst", vel, 0);
    chk("vel_valid_midrst", vel_valid, 0);
    rst_n = 1'b1;
    st = 2'b00;
    for (int i = 0; i < 5; i++) begin
      st = nxt(st, 1'b1);
      drive(st, 3);
    end
    tick(84);
    chk("vel_restart_before", vel_valid, 0);
    tick(1);
    chk("vel_restart_pulse", vel_valid, 1);
    chk("vel_restart_5", vel, 5);
`else
    vv0 = vv_cnt;
    chk("vel_tied", vel, 0);
    chk("vel_valid_never", vv0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
